// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   localparam logic [4:0] REG_X0 = 5'd0;

   // Control-bit bundle loaded into ID/EX or MEM/WB when a bubble is inserted
   localparam int              BUBBLE_W    = 8;
   localparam logic [BUBBLE_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       ex_rd;
   logic             ex_MemRead;
   logic             ex_branch_taken;
   logic             mem_MemRead;
   logic             mem_MemWrite;
   logic             dmem_ready;

   logic             dmem_req;
   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             mem_wb_flush;
   logic [CNT_W-1:0] stall_count;
   logic             mem_timeout;
   logic             state_o;

   // master: pipeline/datapath side; slave: the hazard controller
   modport master (
      output id_rs1, id_rs2, ex_rd, ex_MemRead, ex_branch_taken,
             mem_MemRead, mem_MemWrite, dmem_ready,
      input  dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en,
             if_id_flush, id_ex_flush, mem_wb_flush,
             stall_count, mem_timeout, state_o
   );

   modport slave (
      input  id_rs1, id_rs2, ex_rd, ex_MemRead, ex_branch_taken,
             mem_MemRead, mem_MemWrite, dmem_ready,
      output dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en,
             if_id_flush, id_ex_flush, mem_wb_flush,
             stall_count, mem_timeout, state_o
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// rtl/pipeline_hazard_ctrl_hazard_detect.sv - combinational load-use compare, shared with forwarding
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic [4:0] ex_rd_i,
   input  logic       ex_mem_read_i,
   output logic       load_use_o
);

   // x0 is hardwired zero, so a load targeting it can never create a dependency
   assign load_use_o = ex_mem_read_i && (ex_rd_i != REG_X0) &&
                       ((id_rs1_i == ex_rd_i) || (id_rs2_i == ex_rd_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer with memory-wait FSM, stall counter and timeout flag
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic clk,
   input  logic reset_n,
   pipeline_hazard_ctrl_if.slave bus
);

   localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_count_q, stall_count_d;
   logic              mem_timeout_q, mem_timeout_d;

   logic load_use;
   logic mem_acc;
   logic mem_stall;
   logic pc_en, if_id_en, id_ex_en, ex_mem_en;
   logic if_id_flush, id_ex_flush, mem_wb_flush, dmem_req;

   hazard_detect u_hazard_detect (
      .id_rs1_i      (bus.id_rs1),
      .id_rs2_i      (bus.id_rs2),
      .ex_rd_i       (bus.ex_rd),
      .ex_mem_read_i (bus.ex_MemRead),
      .load_use_o    (load_use)
   );

   always_comb begin
      mem_acc   = bus.mem_MemRead | bus.mem_MemWrite;
      mem_stall = ((state_q == RUN) && mem_acc && !bus.dmem_ready) ||
                  ((state_q == MEM_WAIT) && !bus.dmem_ready);

      state_d = state_q;
      case (state_q)
         RUN:      if (mem_acc && !bus.dmem_ready) state_d = MEM_WAIT;
         MEM_WAIT: if (bus.dmem_ready)             state_d = RUN;
         default:  state_d = RUN;
      endcase

      wait_cnt_d = wait_cnt_q;
      if ((state_q == RUN) && (state_d == MEM_WAIT))
         wait_cnt_d = '0;
      else if ((state_q == MEM_WAIT) && (wait_cnt_q != TIMEOUT_V))
         wait_cnt_d = wait_cnt_q + WAIT_W'(1);

      mem_timeout_d = mem_timeout_q | (wait_cnt_d == TIMEOUT_V);

      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      dmem_req     = (state_q == MEM_WAIT) || mem_acc;

      // Reset forces the pipeline registers to hold bubbles without waiting for a clock
      if (!reset_n) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         mem_wb_flush = 1'b1;
         dmem_req     = 1'b0;
      end else if (mem_stall) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (bus.ex_branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
      end else if (load_use) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_flush  = 1'b1;
      end

      stall_count_d = pc_en ? stall_count_q : stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         stall_count_q <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         stall_count_q <= stall_count_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign bus.dmem_req     = dmem_req;
   assign bus.pc_en        = pc_en;
   assign bus.if_id_en     = if_id_en;
   assign bus.id_ex_en     = id_ex_en;
   assign bus.ex_mem_en    = ex_mem_en;
   assign bus.if_id_flush  = if_id_flush;
   assign bus.id_ex_flush  = id_ex_flush;
   assign bus.mem_wb_flush = mem_wb_flush;
   assign bus.stall_count  = stall_count_q;
   assign bus.mem_timeout  = mem_timeout_q;
   assign bus.state_o      = (state_q == MEM_WAIT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_fail;

   pipeline_hazard_ctrl_if #(.CNT_W(4)) bus ();

   pipeline_hazard_ctrl #(
      .MEM_TIMEOUT (4),
      .CNT_W       (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.id_rs1          = 5'd0;
      bus.id_rs2          = 5'd0;
      bus.ex_rd           = 5'd0;
      bus.ex_MemRead      = 1'b0;
      bus.ex_branch_taken = 1'b0;
      bus.mem_MemRead     = 1'b0;
      bus.mem_MemWrite    = 1'b0;
      bus.dmem_ready      = 1'b0;
   endtask

   // en = {pc_en, if_id_en, id_ex_en, ex_mem_en}, fl = {if_id, id_ex, mem_wb}
   task automatic chk_ctrl(input string tag, input logic [3:0] en, input logic [2:0] fl, input logic req);
      chk({tag, ".en"},  {28'd0, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en}, {28'd0, en});
      chk({tag, ".fl"},  {29'd0, bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush}, {29'd0, fl});
      chk({tag, ".req"}, {31'd0, bus.dmem_req}, {31'd0, req});
   endtask

   task automatic chk_regs(input string tag, input logic st, input logic [3:0] cnt, input logic to);
      chk({tag, ".state"}, {31'd0, bus.state_o}, {31'd0, st});
      chk({tag, ".cnt"},   {28'd0, bus.stall_count}, {28'd0, cnt});
      chk({tag, ".tout"},  {31'd0, bus.mem_timeout}, {31'd0, to});
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      idle();
      reset_n = 1'b0;
      bus.mem_MemRead = 1'b1;
      #2;
      chk_regs("reset", 1'b0, 4'd0, 1'b0);
      chk_ctrl("reset", 4'b0000, 3'b111, 1'b0);
      tick();
      reset_n = 1'b1;
      idle();
      #1;
      chk_ctrl("normal", 4'b1111, 3'b000, 1'b0);

      bus.dmem_ready = 1'b1;
      #1;
      chk_ctrl("stray_ready", 4'b1111, 3'b000, 1'b0);
      tick();
      chk_regs("stray_ready", 1'b0, 4'd0, 1'b0);

      // load-use on rs1, then the load moves to MEM and completes at once
      idle();
      bus.ex_MemRead = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
      #1;
      chk_ctrl("lu_rs1", 4'b0011, 3'b010, 1'b0);
      tick();
      chk_regs("lu_rs1", 1'b0, 4'd1, 1'b0);
      idle();
      bus.mem_MemRead = 1'b1; bus.dmem_ready = 1'b1;
      #1;
      chk_ctrl("lu_after", 4'b1111, 3'b000, 1'b1);
      tick();
      chk_regs("lu_after", 1'b0, 4'd1, 1'b0);

      idle();
      bus.ex_MemRead = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
      #1;
      chk_ctrl("lu_x0", 4'b1111, 3'b000, 1'b0);
      tick();
      bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7;
      #1;
      chk_ctrl("lu_rs2", 4'b0011, 3'b010, 1'b0);
      tick();
      chk_regs("lu_rs2", 1'b0, 4'd2, 1'b0);

      // load with three not-ready cycles
      idle();
      bus.mem_MemRead = 1'b1;
      #1;
      chk_ctrl("mw0", 4'b0000, 3'b001, 1'b1);
      tick();
      chk_regs("mw0", 1'b1, 4'd3, 1'b0);
      chk_ctrl("mw1", 4'b0000, 3'b001, 1'b1);
      tick();
      chk_ctrl("mw2", 4'b0000, 3'b001, 1'b1);
      tick();
      chk_regs("mw2", 1'b1, 4'd5, 1'b0);
      bus.dmem_ready = 1'b1;
      #1;
      chk_ctrl("mw_rdy", 4'b1111, 3'b000, 1'b1);
      tick();
      chk_regs("mw_rdy", 1'b0, 4'd5, 1'b0);

      idle();
      bus.mem_MemWrite = 1'b1; bus.dmem_ready = 1'b1;
      #1;
      chk_ctrl("st_zero", 4'b1111, 3'b000, 1'b1);
      tick();
      chk_regs("st_zero", 1'b0, 4'd5, 1'b0);

      idle();
      bus.ex_branch_taken = 1'b1; bus.ex_MemRead = 1'b1; bus.ex_rd = 5'd3; bus.id_rs1 = 5'd3;
      #1;
      chk_ctrl("br_lu", 4'b1111, 3'b110, 1'b0);
      tick();
      chk_regs("br_lu", 1'b0, 4'd5, 1'b0);

      // branch held back by a memory stall, then flushes on release
      idle();
      bus.ex_branch_taken = 1'b1; bus.mem_MemRead = 1'b1;
      #1;
      chk_ctrl("br_ms0", 4'b0000, 3'b001, 1'b1);
      tick();
      chk_ctrl("br_ms1", 4'b0000, 3'b001, 1'b1);
      tick();
      chk_regs("br_ms1", 1'b1, 4'd7, 1'b0);
      bus.dmem_ready = 1'b1;
      #1;
      chk_ctrl("br_rel", 4'b1111, 3'b110, 1'b1);
      tick();
      chk_regs("br_rel", 1'b0, 4'd7, 1'b0);

      // timeout: entry cycle plus five wait cycles with ready low
      idle();
      bus.mem_MemRead = 1'b1;
      tick();
      tick();
      tick();
      tick();
      chk_regs("to_w3", 1'b1, 4'd11, 1'b0);
      tick();
      chk_regs("to_w4", 1'b1, 4'd12, 1'b1);
      tick();
      bus.dmem_ready = 1'b1;
      tick();
      chk_regs("to_done", 1'b0, 4'd13, 1'b1);

      // asynchronous reset in the middle of a wait
      idle();
      bus.mem_MemRead = 1'b1;
      tick();
      tick();
      chk_regs("pre_rst", 1'b1, 4'd15, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_regs("mid_rst", 1'b0, 4'd0, 1'b0);
      chk_ctrl("mid_rst", 4'b0000, 3'b111, 1'b0);
      tick();
      reset_n = 1'b1;

      // counter wrap on a held load-use stall
      idle();
      bus.ex_MemRead = 1'b1; bus.ex_rd = 5'd9; bus.id_rs2 = 5'd9;
      repeat (15) tick();
      chk_regs("wrap15", 1'b0, 4'd15, 1'b0);
      tick();
      chk_regs("wrap0", 1'b0, 4'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage 64-bit pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It detects load-use hazards and taken branches, and handles a variable-latency data-memory req/ready handshake. It drives per-register enable and flush controls to the pipeline registers. It also keeps a stall-cycle performance counter and a sticky memory-timeout flag.

Parameters:
MEM_TIMEOUT, 64, MEM_WAIT cycles after which mem_timeout is set
CNT_W, 32, width of stall_count

Ports:
clk  in  1  pipeline clock (all pipeline registers use the same clock)
reset_n  in  1  asynchronous active-low reset
id_rs1  in  5  rs1 of the instruction in ID
id_rs2  in  5  rs2 of the instruction in ID
ex_rd  in  5  rd of the instruction in EX
ex_MemRead  in  1  EX instruction is a load
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_MemRead  in  1  MEM instruction is a load
mem_MemWrite  in  1  MEM instruction is a store
dmem_ready  in  1  data memory completes the access this cycle
dmem_req  out  1  data memory access request
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID load enable
id_ex_en  out  1  ID/EX load enable
ex_mem_en  out  1  EX/MEM load enable
if_id_flush  out  1  load bubble into IF/ID
id_ex_flush  out  1  load bubble (all controls 0) into ID/EX
mem_wb_flush  out  1  load bubble (RegWrite=0, MemtoReg=0) into MEM/WB
stall_count  out  CNT_W  cycles with pc_en=0, wraps
mem_timeout  out  1  sticky timeout flag
state_o  out  1  0=RUN, 1=MEM_WAIT (debug)

Behaviour:
- While reset_n=0: state=RUN, wait_cnt=0, stall_count=0, mem_timeout=0. All enables=0, all flushes=1, dmem_req=0. Applies immediately (asynchronous), including mid-MEM_WAIT; an outstanding access is abandoned.
- mem_acc = mem_MemRead | mem_MemWrite. dmem_req = mem_acc in RUN and 1 in MEM_WAIT. Held stable until dmem_ready, since EX/MEM is frozen.
- load_use = ex_MemRead & ex_rd!=0 & (id_rs1==ex_rd | id_rs2==ex_rd).
- mem_stall = (RUN & mem_acc & !dmem_ready) | (MEM_WAIT & !dmem_ready).
- Decisions are combinational from state and inputs. Priority: mem_stall > ex_branch_taken > load_use > normal.
- mem_stall: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_flush=1, other flushes=0. Branch and load-use are ignored and re-evaluated after release.
- branch: all enables=1, if_id_flush=1, id_ex_flush=1.
- load_use (no branch): pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=1. Exactly one bubble; the next cycle the load is in MEM and no longer matches.
- normal: all enables=1, all flushes=0.
- FSM transitions:
  - RUN->MEM_WAIT when mem_acc & !dmem_ready.
  - MEM_WAIT->RUN when dmem_ready. That cycle, all enables=1 and mem_wb_flush=0, so the completed access advances into MEM/WB with its ReadData.
  - Zero-wait access (ready in same cycle as first request) stays in RUN with no stall.
- wait_cnt:
  - Cleared on entry to MEM_WAIT.
  - Increments each MEM_WAIT cycle and saturates at MEM_TIMEOUT.
  - When it reaches MEM_TIMEOUT, mem_timeout is set and stays set until reset. The FSM keeps waiting.
- stall_count increments on every clk edge where pc_en=0 and reset_n=1, and wraps to 0 after 2^CNT_W-1.
- x0 never causes a load-use stall. dmem_ready outside a request is ignored.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum (RUN, MEM_WAIT)
  - REG_X0 constant (5'd0)
  - bubble-control constant for MEM/WB and ID/EX (all control bits 0)
- Sub-module hazard_detect holds the combinational load_use compare. It is reused by the forwarding unit.
- FSM, counters and output decode stay in the top.

Test Plan:
- ex_MemRead=1, ex_rd=5, id_rs1=5 in RUN, no mem access -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1, stall_count 0->1. Repeat with ex_rd=0 -> no stall.
- mem_MemRead=1, dmem_ready low 3 cycles then high:
  - state_o=1 for 3 cycles, dmem_req=1 for 4 cycles
  - enables 0 and mem_wb_flush=1 for 3 cycles, then all enables=1 on the ready cycle
  - stall_count=3
- mem_MemWrite=1 with dmem_ready=1 in same cycle -> no MEM_WAIT, pc_en=1, mem_wb_flush=0.
- ex_branch_taken=1 with a load-use match -> if_id_flush=1, id_ex_flush=1, pc_en=1. Same branch during a mem_stall -> enables 0, flushes of IF/ID and ID/EX =0 until ready, then flush.
- MEM_TIMEOUT=4, dmem_ready held low 6 cycles -> mem_timeout rises after 4th wait cycle, stays 1 after ready. Pulse reset_n low mid-wait -> state RUN, counters 0, mem_timeout 0 immediately.
- Force 2^CNT_W-1 stall cycles (CNT_W=4 build) -> stall_count wraps 15->0.
